reg_operand_fetch_fpga: RTL and testbench
=========================================

# reg_operand_fetch_fpga

Read-side client for the 128x32b, 3-read/2-write FPGA vector/scalar register file. Accepts operand-fetch requests naming up to three source registers, drives the file's three read-address ports, absorbs the one-cycle block-RAM read latency, and returns the operands under valid/ready flow control. It snoops both register-file write ports so every delivered operand reflects all writes committed before delivery, including same-cycle and in-flight writes that the block RAM would otherwise miss.

## Interface
- TAG_WIDTH, 6, width of the opaque request tag carried to the output
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid & req_ready
- req_src0/1/2  in  7 each  source register addresses
- req_mask  in  3  bit i set = source i needed
- req_tag  in  TAG_WIDTH  request tag
- rd0/1/2_addr  out  7 each  to register-file read ports
- rd0/1/2_data  in  32 each  from register file, valid the cycle after address is driven
- wr0_en, wr1_en  in  1 each  snooped register-file write enables
- wr0_addr, wr1_addr  in  7 each  snooped write addresses
- wr0_data, wr1_data  in  32 each  snooped write data
- op_valid  out  1  operands present
- op_ready  in  1  consumer accepts when op_valid & op_ready
- op_data0/1/2  out  32 each  operands; 0 for unmasked sources
- op_tag  out  TAG_WIDTH  tag of the delivered request

## Operation
- Effective write each cycle mirrors the file's arbitration: if wr1_en then (wr1_addr, wr1_data); else if wr0_en then (wr0_addr, wr0_data); else none. wr0 is ignored when both enabled.
- Two stages: A (read in flight: a_valid, a_src[3], a_mask, a_tag, per-source fwd flag + 32b fwd data) and O (output register: op_valid, op_data, op_tag, op_mask/op_src).
- rdi_addr = req_srci when a request is accepted this cycle; else a_srci when a_valid; else 0. Unmasked sources drive 0.
- A advances into O when a_valid & (!op_valid | op_ready). req_ready = !a_valid | A advances.
- Operand selection on advance, per masked source i, priority: (1) effective write this cycle hits a_srci -> write data; (2) fwd flag set -> fwd data; (3) rdi_data.
- Every cycle A is valid (including cycle of acceptance), fwd flag/data for source i are overwritten with this cycle's effective-write match (flag cleared if no match). While A holds, addresses stay driven so BRAM re-reads each cycle.
- While op_valid & !op_ready, each effective write matching a masked op_srci replaces op_datai.
- O cleared on op_ready with no advance; overwritten on advance.
- States: EMPTY (!a_valid,!op_valid), FETCH (a_valid only), OUT (op_valid only), FULL (both). FULL & !op_ready holds both; req_ready=0.

## Timing
- Reset: op_valid=0, op_data*=0, op_tag=0, rd*_addr=0, a_valid=0, all fwd flags 0; req_ready=1 after reset.
- Latency: request accepted at edge N -> op_valid at edge N+1 (available cycle N+1), given O free.
- Throughput: one request per cycle with op_ready held high.
- Write in accept cycle N: captured in fwd, delivered. Write in cycle N+1 (advance cycle): delivered via priority (1). Write while held in O: updates op_data.
- Same-cycle wr0/wr1 to different addresses: only wr1 forwarded, matching file contents.
- Reset asserted mid-operation: all in-flight requests discarded, outputs return to reset values immediately (asynchronous).

## Test plan
- Reset mid-stream with a_valid and op_valid set -> op_valid=0, op_data*=0, rd*_addr=0 while rst low; req_ready=1 first cycle after release.
- File preloaded r5=0x11, r9=0x22, r127=0x33; request src=(5,9,127), mask=3'b111, tag=0x2A -> op_valid one cycle later, data (0x11,0x22,0x33), tag 0x2A.
- Back-to-back 8 requests, op_ready=1 -> 8 consecutive op_valid cycles, tags in order, no bubbles.
- Request src0=7 with wr1 writing r7=0xDEAD in accept cycle -> op_data0=0xDEAD; repeat with write in following cycle -> 0xDEAD; wr0 r7=0x1 and wr1 r8=0x2 same cycle -> op_data0 unchanged old value.
- op_ready=0 for 5 cycles with second request in A; write r3=0xBEEF during hold where both hold src 3 -> both deliveries show 0xBEEF; req_ready=0 during hold.
- mask=3'b010 with src0=src2=4 and write to r4 -> op_data0=op_data2=0, op_data1=file value; rd0_addr=rd2_addr=0.

Source files
------------

// File: rtl/reg_operand_fetch_fpga_if.sv
// Purpose: bundles the operand-fetch request channel, the register-file read
//          ports, the snooped register-file write ports and the operand
//          delivery channel into one interface.
// Modports:
//   slave  - used by reg_operand_fetch_fpga (drives req_ready, rd*_addr, op_*)
//   master - used by the environment (drives requests, read data, writes,
//            op_ready)
interface reg_operand_fetch_fpga_if #(
  parameter int unsigned TAG_WIDTH = 6
);
  localparam int unsigned AW = 7;
  localparam int unsigned DW = 32;

  // Request channel
  logic                 req_valid;
  logic                 req_ready;
  logic [AW-1:0]        req_src0;
  logic [AW-1:0]        req_src1;
  logic [AW-1:0]        req_src2;
  logic [2:0]           req_mask;
  logic [TAG_WIDTH-1:0] req_tag;

  // Register-file read ports
  logic [AW-1:0]        rd0_addr;
  logic [AW-1:0]        rd1_addr;
  logic [AW-1:0]        rd2_addr;
  logic [DW-1:0]        rd0_data;
  logic [DW-1:0]        rd1_data;
  logic [DW-1:0]        rd2_data;

  // Snooped register-file write ports
  logic                 wr0_en;
  logic [AW-1:0]        wr0_addr;
  logic [DW-1:0]        wr0_data;
  logic                 wr1_en;
  logic [AW-1:0]        wr1_addr;
  logic [DW-1:0]        wr1_data;

  // Operand delivery channel
  logic                 op_valid;
  logic                 op_ready;
  logic [DW-1:0]        op_data0;
  logic [DW-1:0]        op_data1;
  logic [DW-1:0]        op_data2;
  logic [TAG_WIDTH-1:0] op_tag;

  modport slave (
    input  req_valid, req_src0, req_src1, req_src2, req_mask, req_tag,
    output req_ready,
    output rd0_addr, rd1_addr, rd2_addr,
    input  rd0_data, rd1_data, rd2_data,
    input  wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
    output op_valid, op_data0, op_data1, op_data2, op_tag,
    input  op_ready
  );

  modport master (
    output req_valid, req_src0, req_src1, req_src2, req_mask, req_tag,
    input  req_ready,
    input  rd0_addr, rd1_addr, rd2_addr,
    output rd0_data, rd1_data, rd2_data,
    output wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
    input  op_valid, op_data0, op_data1, op_data2, op_tag,
    output op_ready
  );
endinterface

// File: rtl/reg_operand_fetch_fpga.sv
// Purpose: read-side client of the 128x32b 3R/2W block-RAM register file.
//          Takes requests for up to three source registers, drives the read
//          ports, hides the one-cycle read latency and returns operands under
//          valid/ready. Both write ports are snooped so delivered operands
//          include every write committed before delivery.
// Ports:
//   clk  - clock, all state on the rising edge
//   rst  - asynchronous active-low reset
//   bus  - request / read-port / write-snoop / operand channels (slave side)
module reg_operand_fetch_fpga #(
  parameter int unsigned TAG_WIDTH = 6
) (
  input logic                    clk,
  input logic                    rst,
  reg_operand_fetch_fpga_if.slave bus
);
  localparam int unsigned AW = 7;
  localparam int unsigned DW = 32;
  localparam int unsigned NS = 3;

  // Bit 0 = stage A (read in flight) valid, bit 1 = stage O (output) valid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FETCH = 2'b01,
    ST_OUT   = 2'b10,
    ST_FULL  = 2'b11
  } state_t;

  state_t               r_state;

  // Stage A
  logic [AW-1:0]        r_a_src      [NS];
  logic [NS-1:0]        r_a_mask;
  logic [TAG_WIDTH-1:0] r_a_tag;
  logic [NS-1:0]        r_a_fwd;
  logic [DW-1:0]        r_a_fwd_data [NS];

  // Stage O
  logic [DW-1:0]        r_op_data    [NS];
  logic [AW-1:0]        r_op_src     [NS];
  logic [NS-1:0]        r_op_mask;
  logic [TAG_WIDTH-1:0] r_op_tag;

  logic                 w_a_valid;
  logic                 w_op_valid;
  logic                 w_adv;
  logic                 w_req_ready;
  logic                 w_accept;
  logic                 w_a_next;
  logic                 w_op_next;
  logic                 w_we;
  logic [AW-1:0]        w_waddr;
  logic [DW-1:0]        w_wdata;
  logic [AW-1:0]        w_req_src    [NS];
  logic [DW-1:0]        w_rd_data    [NS];
  logic [AW-1:0]        w_rd_addr    [NS];
  logic [DW-1:0]        w_sel        [NS];
  logic [NS-1:0]        w_req_hit;
  logic [NS-1:0]        w_a_hit;
  logic [NS-1:0]        w_op_hit;

  assign w_req_src[0] = bus.req_src0;
  assign w_req_src[1] = bus.req_src1;
  assign w_req_src[2] = bus.req_src2;
  assign w_rd_data[0] = bus.rd0_data;
  assign w_rd_data[1] = bus.rd1_data;
  assign w_rd_data[2] = bus.rd2_data;

  // Pipeline control; rst gates acceptance so nothing is read while in reset.
  always_comb begin
    w_a_valid   = (r_state == ST_FETCH) || (r_state == ST_FULL);
    w_op_valid  = (r_state == ST_OUT)   || (r_state == ST_FULL);
    w_adv       = w_a_valid && (!w_op_valid || bus.op_ready);
    w_req_ready = rst && (!w_a_valid || w_adv);
    w_accept    = bus.req_valid && w_req_ready;
    w_a_next    = w_accept || (w_a_valid && !w_adv);
    w_op_next   = w_adv || (w_op_valid && !bus.op_ready);
  end

  // Effective write mirrors the file's arbitration: wr1 wins over wr0.
  always_comb begin
    w_we    = bus.wr1_en || bus.wr0_en;
    w_waddr = bus.wr1_en ? bus.wr1_addr : bus.wr0_addr;
    w_wdata = bus.wr1_en ? bus.wr1_data : bus.wr0_data;
  end

  // Per-source write hits, operand select and read-address steering.
  always_comb begin
    w_req_hit = '0;
    w_a_hit   = '0;
    w_op_hit  = '0;
    for (int i = 0; i < int'(NS); i++) begin
      w_req_hit[i] = w_we && (w_waddr == w_req_src[i]);
      w_a_hit[i]   = w_we && (w_waddr == r_a_src[i]);
      w_op_hit[i]  = w_we && (w_waddr == r_op_src[i]);
      // Current write beats the captured forward, which beats the stale BRAM.
      if (w_a_hit[i])        w_sel[i] = w_wdata;
      else if (r_a_fwd[i])   w_sel[i] = r_a_fwd_data[i];
      else                   w_sel[i] = w_rd_data[i];
      w_rd_addr[i] = '0;
      if (w_accept) begin
        if (bus.req_mask[i]) w_rd_addr[i] = w_req_src[i];
      end else if (w_a_valid) begin
        if (r_a_mask[i])     w_rd_addr[i] = r_a_src[i];
      end
    end
  end

  // State, stage A and stage O registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_EMPTY;
      r_a_mask  <= '0;
      r_a_tag   <= '0;
      r_a_fwd   <= '0;
      r_op_mask <= '0;
      r_op_tag  <= '0;
      for (int i = 0; i < int'(NS); i++) begin
        r_a_src[i]      <= '0;
        r_a_fwd_data[i] <= '0;
        r_op_data[i]    <= '0;
        r_op_src[i]     <= '0;
      end
    end else begin
      r_state <= state_t'({w_op_next, w_a_next});

      if (w_accept) begin
        r_a_mask <= bus.req_mask;
        r_a_tag  <= bus.req_tag;
      end

      for (int i = 0; i < int'(NS); i++) begin
        if (w_accept) r_a_src[i] <= w_req_src[i];

        // The BRAM misses a write made in the same cycle as its read, so
        // only the most recent cycle's matching write needs remembering.
        r_a_fwd_data[i] <= w_wdata;
        if (w_accept)                r_a_fwd[i] <= w_req_hit[i];
        else if (w_a_valid && !w_adv) r_a_fwd[i] <= w_a_hit[i];
        else                          r_a_fwd[i] <= 1'b0;

        if (w_adv) begin
          r_op_data[i] <= r_a_mask[i] ? w_sel[i] : DW'(0);
          r_op_src[i]  <= r_a_src[i];
        end else if (w_op_valid && bus.op_ready) begin
          r_op_data[i] <= '0;
        end else if (w_op_valid && r_op_mask[i] && w_op_hit[i]) begin
          r_op_data[i] <= w_wdata;
        end
      end

      if (w_adv) begin
        r_op_mask <= r_a_mask;
        r_op_tag  <= r_a_tag;
      end else if (w_op_valid && bus.op_ready) begin
        r_op_mask <= '0;
        r_op_tag  <= '0;
      end
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rd0_addr  = w_rd_addr[0];
  assign bus.rd1_addr  = w_rd_addr[1];
  assign bus.rd2_addr  = w_rd_addr[2];
  assign bus.op_valid  = w_op_valid;
  assign bus.op_data0  = r_op_data[0];
  assign bus.op_data1  = r_op_data[1];
  assign bus.op_data2  = r_op_data[2];
  assign bus.op_tag    = r_op_tag;

endmodule

// File: tb/tb_reg_operand_fetch_fpga.sv
// Purpose: scoreboard bench for reg_operand_fetch_fpga with a behavioural
//          read-first register-file model attached to the read/write ports.
module tb_reg_operand_fetch_fpga;
  localparam int unsigned TW = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_operand_fetch_fpga_if #(.TAG_WIDTH(TW)) bus ();

  reg_operand_fetch_fpga #(.TAG_WIDTH(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Register file model: wr1 wins, read data one cycle after address, read-first.
  logic [31:0] mem [128];
  always @(posedge clk) begin
    if (bus.wr1_en)      mem[bus.wr1_addr] <= bus.wr1_data;
    else if (bus.wr0_en) mem[bus.wr0_addr] <= bus.wr0_data;
    bus.rd0_data <= mem[bus.rd0_addr];
    bus.rd1_data <= mem[bus.rd1_addr];
    bus.rd2_data <= mem[bus.rd2_addr];
  end

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [31:0]   d0;
    logic [31:0]   d1;
    logic [31:0]   d2;
    logic          contig;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   last_cyc = -10;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops and compares on every delivered operand set.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst && bus.op_valid && bus.op_ready) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_op: got tag 0x%0h expected no delivery", bus.op_tag);
        end else begin
          e = q.pop_front();
          check("op_tag", 32'(bus.op_tag), 32'(e.tag));
          check("op_data0", bus.op_data0, e.d0);
          check("op_data1", bus.op_data1, e.d1);
          check("op_data2", bus.op_data2, e.d2);
          if (e.contig) check("no_bubble", 32'(cyc - last_cyc), 32'd1);
          last_cyc = cyc;
        end
      end
    end
  end

  task automatic clr_wr();
    bus.wr0_en = 1'b0;
    bus.wr1_en = 1'b0;
  endtask

  task automatic set_wr(input bit port, input logic [6:0] a, input logic [31:0] d);
    if (port) begin bus.wr1_en = 1'b1; bus.wr1_addr = a; bus.wr1_data = d; end
    else      begin bus.wr0_en = 1'b1; bus.wr0_addr = a; bus.wr0_data = d; end
  endtask

  task automatic preload(input logic [6:0] a, input logic [31:0] d);
    set_wr(1'b1, a, d);
    @(posedge clk); #1;
    clr_wr();
  endtask

  // Issue one request; any write set up by the caller lasts for the accept cycle.
  task automatic send(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                      input logic [2:0] m, input logic [TW-1:0] tag,
                      input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2,
                      input bit contig);
    int k;
    bus.req_valid = 1'b1;
    bus.req_src0 = s0; bus.req_src1 = s1; bus.req_src2 = s2;
    bus.req_mask = m;  bus.req_tag  = tag;
    q.push_back('{tag: tag, d0: e0, d1: e1, d2: e2, contig: contig});
    #1;
    k = 0;
    while (!bus.req_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    if (!bus.req_ready) check("req_ready_timeout", 32'(bus.req_ready), 32'd1);
    check("rd0_addr", 32'(bus.rd0_addr), m[0] ? 32'(s0) : 32'd0);
    check("rd1_addr", 32'(bus.rd1_addr), m[1] ? 32'(s1) : 32'd0);
    check("rd2_addr", 32'(bus.rd2_addr), m[2] ? 32'(s2) : 32'd0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    clr_wr();
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() != 0 && k < 100) begin
      @(posedge clk);
      k++;
    end
    #1;
    check("drain", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_src0 = '0; bus.req_src1 = '0; bus.req_src2 = '0;
    bus.req_mask = '0; bus.req_tag = '0;
    bus.wr0_en = 1'b0; bus.wr0_addr = '0; bus.wr0_data = '0;
    bus.wr1_en = 1'b0; bus.wr1_addr = '0; bus.wr1_data = '0;
    bus.op_ready = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_op_valid", 32'(bus.op_valid), 32'd0);
    check("rst_op_data0", bus.op_data0, 32'd0);
    check("rst_op_tag", 32'(bus.op_tag), 32'd0);
    check("rst_rd0_addr", 32'(bus.rd0_addr), 32'd0);
    rst = 1'b1;
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;

    // Preload file through the write port
    preload(7'd5, 32'h11);
    preload(7'd9, 32'h22);
    preload(7'd127, 32'h33);
    preload(7'd10, 32'hA0A0);
    preload(7'd3, 32'h3333);
    preload(7'd4, 32'h4444);
    preload(7'd8, 32'h88);
    for (int i = 0; i < 8; i++) preload(7'(20 + i), 32'h100 + 32'(i));

    // Basic fetch and one-cycle latency
    send(7'd5, 7'd9, 7'd127, 3'b111, 6'h2A, 32'h11, 32'h22, 32'h33, 1'b0);
    check("lat_a_only", 32'(bus.op_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_op_valid", 32'(bus.op_valid), 32'd1);
    drain();

    // Back-to-back, no bubbles
    for (int i = 0; i < 8; i++)
      send(7'(20 + i), 7'd5, 7'd0, 3'b011, 6'(6'h10 + i), 32'h100 + 32'(i), 32'h11, 32'h0, i > 0);
    drain();

    // Write in accept cycle is forwarded
    preload(7'd7, 32'h77);
    set_wr(1'b1, 7'd7, 32'hDEAD);
    send(7'd7, 7'd0, 7'd0, 3'b001, 6'h01, 32'hDEAD, 32'h0, 32'h0, 1'b0);
    drain();

    // Write in advance cycle is forwarded
    preload(7'd7, 32'h77);
    send(7'd7, 7'd0, 7'd0, 3'b001, 6'h02, 32'hDEAD, 32'h0, 32'h0, 1'b0);
    set_wr(1'b1, 7'd7, 32'hDEAD);
    @(posedge clk); #1;
    clr_wr();
    drain();

    // wr0 loses to wr1 in the same cycle
    preload(7'd7, 32'h77);
    set_wr(1'b0, 7'd7, 32'h1);
    set_wr(1'b1, 7'd8, 32'h2);
    send(7'd7, 7'd8, 7'd0, 3'b011, 6'h03, 32'h77, 32'h2, 32'h0, 1'b0);
    drain();
    send(7'd7, 7'd8, 7'd0, 3'b011, 6'h04, 32'h77, 32'h2, 32'h0, 1'b0);
    drain();

    // Hold with both stages full; write during hold reaches both
    bus.op_ready = 1'b0;
    send(7'd3, 7'd0, 7'd0, 3'b001, 6'h05, 32'hBEEF, 32'h0, 32'h0, 1'b0);
    send(7'd3, 7'd0, 7'd0, 3'b001, 6'h06, 32'hBEEF, 32'h0, 32'h0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      check("hold_req_ready", 32'(bus.req_ready), 32'd0);
      check("hold_op_valid", 32'(bus.op_valid), 32'd1);
      if (k == 1) set_wr(1'b1, 7'd3, 32'hBEEF);
      @(posedge clk); #1;
      clr_wr();
    end
    bus.op_ready = 1'b1;
    drain();

    // Unmasked sources read as zero and drive address zero
    set_wr(1'b1, 7'd4, 32'h4B4B);
    send(7'd4, 7'd10, 7'd4, 3'b010, 6'h07, 32'h0, 32'hA0A0, 32'h0, 1'b0);
    drain();

    // Asynchronous reset mid-stream
    bus.op_ready = 1'b0;
    send(7'd5, 7'd9, 7'd127, 3'b111, 6'h08, 32'h11, 32'h22, 32'h33, 1'b0);
    send(7'd3, 7'd0, 7'd0, 3'b001, 6'h09, 32'hBEEF, 32'h0, 32'h0, 1'b0);
    bus.req_valid = 1'b1;
    bus.req_src0 = 7'd5; bus.req_src1 = 7'd9; bus.req_src2 = 7'd127;
    bus.req_mask = 3'b111; bus.req_tag = 6'h0B;
    #1;
    rst = 1'b0;
    #1;
    q.delete();
    check("mrst_op_valid", 32'(bus.op_valid), 32'd0);
    check("mrst_op_data0", bus.op_data0, 32'd0);
    check("mrst_op_data1", bus.op_data1, 32'd0);
    check("mrst_op_data2", bus.op_data2, 32'd0);
    check("mrst_op_tag", 32'(bus.op_tag), 32'd0);
    check("mrst_rd0_addr", 32'(bus.rd0_addr), 32'd0);
    check("mrst_rd1_addr", 32'(bus.rd1_addr), 32'd0);
    check("mrst_rd2_addr", 32'(bus.rd2_addr), 32'd0);
    @(posedge clk); #1;
    check("mrst_op_valid_hold", 32'(bus.op_valid), 32'd0);
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.op_ready = 1'b1;
    #1;
    check("mrst_req_ready", 32'(bus.req_ready), 32'd1);
    check("mrst_op_valid_rel", 32'(bus.op_valid), 32'd0);
    @(posedge clk); #1;
    send(7'd5, 7'd9, 7'd127, 3'b111, 6'h2B, 32'h11, 32'h22, 32'h33, 1'b0);
    drain();

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
